// File: rtl/udp_arb_pkg.sv
// ---------------------------------------------------------------------------
// udp_arb_pkg
// Shared types and constants for the UDP0 transmit arbiter.
//   arb_state_t     : arbiter FSM state (IDLE / PASS / DRAIN)
//   UDP_MAX_PAYLOAD : largest UDP payload that fits one Ethernet frame
//   DROP_CNT_W      : width of the dropped-packet counter
//   sat_inc         : saturating increment for the drop counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package udp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int DROP_CNT_W      = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after the pointer, wrapping around.
//   req  in  N         request vector
//   ptr  in  IW        highest-priority index for this scan
//   gnt  out N         one-hot winner (0 when no request)
//   idx  out IW        binary index of the winner
//   any  out 1         at least one request present
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// udp_tx_arbiter
// Packet-granular round-robin arbiter sharing the UDP0 transmit stream of the
// MII/UDP core between NUM_SRC requesters. Whole packets are granted, beats
// pass through combinationally, payloads longer than MAX_BEATS are cut and the
// remainder discarded, and a client disconnect mid-packet drains the source.
//   Clk, Reset        clock / asynchronous active-high reset
//   SrcTxData/Valid/Last/Ready  per-source byte streams (source i = byte i)
//   UDP0_Connected    client connected indication from the core
//   UDP0_TxData/Valid/Last/Ready  stream towards the core
//   Grant             one-hot current owner (registered)
//   Busy              arbiter is not idle
//   DropCount         truncated or discarded packets, saturating
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = UDP_MAX_PAYLOAD
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [8*NUM_SRC-1:0]  SrcTxData,
  input  logic [NUM_SRC-1:0]    SrcTxValid,
  input  logic [NUM_SRC-1:0]    SrcTxLast,
  output logic [NUM_SRC-1:0]    SrcTxReady,
  input  logic                  UDP0_Connected,
  output logic [7:0]            UDP0_TxData,
  output logic                  UDP0_TxValid,
  output logic                  UDP0_TxLast,
  input  logic                  UDP0_TxReady,
  output logic [NUM_SRC-1:0]    Grant,
  output logic                  Busy,
  output logic [DROP_CNT_W-1:0] DropCount
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  arb_state_t            state_reg, state_next;
  logic [NUM_SRC-1:0]    grant_reg, grant_next;
  logic [IW-1:0]         gidx_reg, gidx_next;
  logic [IW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]         beat_cnt_reg, beat_cnt_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic [NUM_SRC-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [7:0]    sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          at_limit;
  logic          handshake;
  logic [IW-1:0] ptr_after;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req (SrcTxValid),
    .ptr (rr_ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Granted source's stream, selected by the registered index
  assign sel_data  = SrcTxData[{gidx_reg, 3'b000} +: 8];
  assign sel_valid = SrcTxValid[gidx_reg];
  assign sel_last  = SrcTxLast[gidx_reg];

  assign at_limit  = (beat_cnt_reg == LAST_BEAT);
  assign handshake = (state_reg == PASS) && sel_valid && UDP0_TxReady;
  assign ptr_after = (gidx_reg == IW'(NUM_SRC - 1)) ? '0 : gidx_reg + IW'(1);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Arbitration / counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grant_reg    <= '0;
      gidx_reg     <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      grant_reg    <= grant_next;
      gidx_reg     <= gidx_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    gidx_next     = gidx_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    drop_cnt_next = drop_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (UDP0_Connected && pick_any) begin
          state_next    = PASS;
          grant_next    = pick_gnt;
          gidx_next     = pick_idx;
          beat_cnt_next = '0;
        end
      end
      PASS: begin
        if (handshake) begin
          beat_cnt_next = beat_cnt_reg + CW'(1);
          // Source's own last wins over a coinciding length cut
          if (sel_last) begin
            state_next  = IDLE;
            grant_next  = '0;
            rr_ptr_next = ptr_after;
          end else if (at_limit) begin
            state_next    = DRAIN;
            drop_cnt_next = sat_inc(drop_cnt_reg);
          end
        end else if (!UDP0_Connected) begin
          // Downstream packet is left open; the core flushes it on disconnect
          state_next    = DRAIN;
          drop_cnt_next = sat_inc(drop_cnt_reg);
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = ptr_after;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    SrcTxReady   = '0;
    UDP0_TxData  = '0;
    UDP0_TxValid = 1'b0;
    UDP0_TxLast  = 1'b0;
    case (state_reg)
      PASS: begin
        UDP0_TxData  = sel_data;
        UDP0_TxValid = sel_valid;
        UDP0_TxLast  = sel_last | at_limit;
        SrcTxReady   = grant_reg & {NUM_SRC{UDP0_TxReady}};
      end
      DRAIN: begin
        SrcTxReady = grant_reg;
      end
      default: ;
    endcase
  end

  assign Grant     = grant_reg;
  assign Busy      = (state_reg != IDLE);
  assign DropCount = drop_cnt_reg;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
  import udp_arb_pkg::*;

  localparam int NS = 4;
  localparam int MB = 1472;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [8*NS-1:0] SrcTxData;
  logic [NS-1:0]   SrcTxValid;
  logic [NS-1:0]   SrcTxLast;
  logic [NS-1:0]   SrcTxReady;
  logic            UDP0_Connected;
  logic [7:0]      UDP0_TxData;
  logic            UDP0_TxValid;
  logic            UDP0_TxLast;
  logic            UDP0_TxReady;
  logic [NS-1:0]   Grant;
  logic            Busy;
  logic [15:0]     DropCount;

  logic [7:0] src_data  [NS];
  logic       src_valid [NS];
  logic       src_last  [NS];

  for (genvar gi = 0; gi < NS; gi++) begin : g_pack
    assign SrcTxData[8*gi +: 8] = src_data[gi];
    assign SrcTxValid[gi]       = src_valid[gi];
    assign SrcTxLast[gi]        = src_last[gi];
  end

  udp_tx_arbiter #(.NUM_SRC(NS), .MAX_BEATS(MB)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .SrcTxData      (SrcTxData),
    .SrcTxValid     (SrcTxValid),
    .SrcTxLast      (SrcTxLast),
    .SrcTxReady     (SrcTxReady),
    .UDP0_Connected (UDP0_Connected),
    .UDP0_TxData    (UDP0_TxData),
    .UDP0_TxValid   (UDP0_TxValid),
    .UDP0_TxLast    (UDP0_TxLast),
    .UDP0_TxReady   (UDP0_TxReady),
    .Grant          (Grant),
    .Busy           (Busy),
    .DropCount      (DropCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Core-side monitor: logs every handshake that the coming edge will take
  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gidx;
    int         cyc;
  } beat_t;
  beat_t log_q[$];

  always @(negedge Clk) begin
    #2;
    if (UDP0_TxValid && UDP0_TxReady) begin
      beat_t b;
      b.data = UDP0_TxData;
      b.last = UDP0_TxLast;
      b.gidx = oh2idx(Grant);
      b.cyc  = cyc;
      log_q.push_back(b);
    end
  end

  // Source driver: presents bytes base, base+1, ... and waits for each handshake
  task automatic src_send(input int i, input logic [7:0] base, input int n);
    logic hs;
    int   budget;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      src_data[i]  = base + 8'(k);
      src_valid[i] = 1'b1;
      src_last[i]  = (k == n - 1);
      hs     = 1'b0;
      budget = 0;
      while (!hs) begin
        #1 hs = SrcTxReady[i];
        @(posedge Clk);
        if (!hs) begin
          budget++;
          if (budget > 4000) begin
            chk($sformatf("src%0d_stall_beat%0d", i, k), budget, 0);
            return;
          end
          @(negedge Clk);
        end
      end
    end
    $display("src%0d packet base 0x%0h len %0d accepted", i, base, n);
  endtask

  task automatic src_idle(input int i);
    @(negedge Clk);
    src_valid[i] = 1'b0;
    src_last[i]  = 1'b0;
    #3;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_base [4];
    int w;
    int n;
    int bad;
    int lasts;

    for (int i = 0; i < NS; i++) begin
      src_data[i]  = '0;
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b0;
    end
    Reset          = 1'b1;
    UDP0_Connected = 1'b1;
    UDP0_TxReady   = 1'b1;

    // ---- reset state ----
    repeat (2) @(negedge Clk);
    #3;
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_ready", 32'(SrcTxReady), 0);
    chk("rst_txvalid", 32'(UDP0_TxValid), 0);
    chk("rst_txlast", 32'(UDP0_TxLast), 0);
    chk("rst_txdata", 32'(UDP0_TxData), 0);
    chk("rst_drop", 32'(DropCount), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // ---- T1: source 1, five bytes 0x10..0x14 ----
    log_q.delete();
    fork
      src_send(1, 8'h10, 5);
      begin
        @(negedge Clk); #3;
        chk("t1_grant_n", 32'(Grant), 0);
        @(negedge Clk); #3;
        chk("t1_grant_n1", 32'(Grant), 32'b0010);
        chk("t1_valid_n1", 32'(UDP0_TxValid), 1);
        chk("t1_data_n1", 32'(UDP0_TxData), 32'h10);
      end
    join
    src_idle(1);
    chk("t1_beats", log_q.size(), 5);
    if (log_q.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("t1_data%0d", k), 32'(log_q[k].data), 32'h10 + k);
        chk($sformatf("t1_last%0d", k), 32'(log_q[k].last), (k == 4) ? 1 : 0);
        chk($sformatf("t1_gidx%0d", k), log_q[k].gidx, 1);
      end
    end
    chk("t1_busy_end", 32'(Busy), 0);
    chk("t1_rrptr", 32'(dut.rr_ptr_reg), 2);

    // ---- T2: sources 0 and 2 continuously valid, 3-byte packets ----
    do_reset();
    log_q.delete();
    fork
      begin src_send(0, 8'h20, 3); src_send(0, 8'h30, 3); src_idle(0); end
      begin src_send(2, 8'h40, 3); src_send(2, 8'h50, 3); src_idle(2); end
    join
    exp_base = '{32'h20, 32'h40, 32'h30, 32'h50};
    chk("t2_beats", log_q.size(), 12);
    if (log_q.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        chk($sformatf("t2_data%0d", k), 32'(log_q[k].data), exp_base[k/3] + (k % 3));
        chk($sformatf("t2_gidx%0d", k), log_q[k].gidx, ((k / 3) % 2 == 0) ? 0 : 2);
        chk($sformatf("t2_last%0d", k), 32'(log_q[k].last), (k % 3 == 2) ? 1 : 0);
        if (k > 0)
          chk($sformatf("t2_gap%0d", k), log_q[k].cyc - log_q[k-1].cyc, (k % 3 == 0) ? 2 : 1);
      end
    end
    chk("t2_drop", 32'(DropCount), 0);

    // ---- T3: core ready toggling during a 4-byte packet from source 3 ----
    log_q.delete();
    fork
      src_send(3, 8'h60, 4);
      begin
        w = 0;
        do begin @(negedge Clk); #3; w++; end while (!Busy && w < 20);
        chk("t3_busy_wait", 32'(Busy), 1);
        n = 0;
        while (Busy && n < 20) begin
          chk($sformatf("t3_mirror%0d", n), 32'(SrcTxReady), UDP0_TxReady ? 32'b1000 : 0);
          n++;
          @(negedge Clk);
          UDP0_TxReady = ~UDP0_TxReady;
          #3;
        end
        chk("t3_pass_cycles", n, 7);
        UDP0_TxReady = 1'b1;
      end
    join
    src_idle(3);
    chk("t3_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t3_data%0d", k), 32'(log_q[k].data), 32'h60 + k);
        chk($sformatf("t3_last%0d", k), 32'(log_q[k].last), (k == 3) ? 1 : 0);
      end
      chk("t3_span", log_q[3].cyc - log_q[0].cyc, 6);
    end

    // ---- T4: 1480-byte packet, cut at 1472 ----
    do_reset();
    log_q.delete();
    src_send(0, 8'h00, 1480);
    src_idle(0);
    chk("t4_beats", log_q.size(), MB);
    bad   = 0;
    lasts = 0;
    foreach (log_q[k]) begin
      if (log_q[k].data !== 8'(k)) bad++;
      if (log_q[k].last) lasts++;
    end
    chk("t4_data_errs", bad, 0);
    chk("t4_last_count", lasts, 1);
    if (log_q.size() == MB) chk("t4_last_pos", 32'(log_q[MB-1].last), 1);
    chk("t4_drop", 32'(DropCount), 1);
    chk("t4_busy_end", 32'(Busy), 0);

    // ---- T5: disconnect after beat 3 of 10 ----
    do_reset();
    log_q.delete();
    fork
      src_send(2, 8'h70, 10);
      begin
        w = 0;
        do begin @(negedge Clk); #3; w++; end while (log_q.size() < 3 && w < 50);
        @(negedge Clk);
        UDP0_Connected = 1'b0;
        UDP0_TxReady   = 1'b0;
        @(negedge Clk); #3;
        chk("t5_drain_busy", 32'(Busy), 1);
        chk("t5_drain_txvalid", 32'(UDP0_TxValid), 0);
        chk("t5_drain_ready", 32'(SrcTxReady), 32'b0100);
        chk("t5_drain_drop", 32'(DropCount), 1);
      end
    join
    src_idle(2);
    chk("t5_beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t5_data%0d", k), 32'(log_q[k].data), 32'h70 + k);
        chk($sformatf("t5_last%0d", k), 32'(log_q[k].last), 0);
      end
    end
    chk("t5_drop", 32'(DropCount), 1);
    chk("t5_idle", 32'(Busy), 0);
    // request while disconnected must stall
    @(negedge Clk);
    src_data[1]  = 8'h80;
    src_valid[1] = 1'b1;
    src_last[1]  = 1'b1;
    repeat (5) @(negedge Clk);
    #3;
    chk("t5_wait_busy", 32'(Busy), 0);
    chk("t5_wait_grant", 32'(Grant), 0);
    chk("t5_wait_ready", 32'(SrcTxReady), 0);
    @(negedge Clk);
    UDP0_Connected = 1'b1;
    UDP0_TxReady   = 1'b1;
    log_q.delete();
    src_send(1, 8'h80, 2);
    src_idle(1);
    chk("t5_recon_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t5_recon_d0", 32'(log_q[0].data), 32'h80);
      chk("t5_recon_d1", 32'(log_q[1].data), 32'h81);
      chk("t5_recon_last", 32'(log_q[1].last), 1);
      chk("t5_recon_gidx", log_q[0].gidx, 1);
    end
    chk("t5_recon_drop", 32'(DropCount), 1);

    // ---- T6: reset pulsed mid-PASS ----
    @(negedge Clk);
    src_data[3]  = 8'h90;
    src_valid[3] = 1'b1;
    src_last[3]  = 1'b0;
    repeat (3) @(negedge Clk);
    #3;
    chk("t6_pre_busy", 32'(Busy), 1);
    Reset = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(Grant), 0);
    chk("t6_rst_busy", 32'(Busy), 0);
    chk("t6_rst_ready", 32'(SrcTxReady), 0);
    chk("t6_rst_txvalid", 32'(UDP0_TxValid), 0);
    chk("t6_rst_txlast", 32'(UDP0_TxLast), 0);
    chk("t6_rst_txdata", 32'(UDP0_TxData), 0);
    chk("t6_rst_drop", 32'(DropCount), 0);
    @(negedge Clk);
    src_data[0]  = 8'hA0;
    src_valid[0] = 1'b1;
    src_last[0]  = 1'b1;
    src_data[3]  = 8'h91;
    src_last[3]  = 1'b1;
    log_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk); #3;
    chk("t6_first_grant", 32'(Grant), 32'b0001);
    chk("t6_first_data", 32'(UDP0_TxData), 32'hA0);
    repeat (3) @(negedge Clk);
    src_valid[0] = 1'b0;
    src_last[0]  = 1'b0;
    src_valid[3] = 1'b0;
    src_last[3]  = 1'b0;
    #3;
    chk("t6_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t6_gidx0", log_q[0].gidx, 0);
      chk("t6_gidx1", log_q[1].gidx, 3);
      chk("t6_data1", 32'(log_q[1].data), 32'h91);
    end
    chk("t6_busy_end", 32'(Busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
